poly_synth: RTL and testbench

POLY_SYNTH -- requirements
Module: poly_synth

---
 rtl/poly_synth_pkg.sv | 26 ++
 rtl/poly_voice_wave.sv | 59 +++++
 rtl/poly_synth.sv | 165 ++++++++++++++++
 tb/tb_poly_synth.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/poly_synth_pkg.sv
// Shared types and constants for the polyphonic synth: waveform codes,
// noise LFSR polynomial/seed and the frame sequencer state type.
package poly_synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW    = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_NOISE  = 2'd3
   } wave_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Right-shifting Galois step: feedback applied when the bit shifted out is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/poly_voice_wave.sv
// Combinational per-voice datapath: phase -> waveform -> envelope-scaled
// signed sample. One instance is time-shared across all voices.
module poly_voice_wave
   import poly_synth_pkg::*;
#(
   parameter int BITDEPTH    = 14,
   parameter int BITFRACTION = 6,
   parameter int ENVBITS     = 8
) (
   input  logic [BITDEPTH+BITFRACTION-1:0] phase_i,
   input  wave_e                           wave_i,
   input  logic [ENVBITS-1:0]              env_i,
   input  logic [15:0]                     lfsr_i,
   output logic signed [BITDEPTH-1:0]      sample_o
);

   localparam int PRW = BITDEPTH + ENVBITS + 1;

   logic [BITDEPTH-1:0]        t;
   logic                       m;
   logic [BITDEPTH-1:0]        t2;
   logic [BITDEPTH-1:0]        tri_raw;
   logic [BITDEPTH-1:0]        noise;
   logic signed [BITDEPTH-1:0] wave_s;
   logic signed [PRW-1:0]      wave_x;
   logic signed [PRW-1:0]      env_x;
   logic signed [PRW-1:0]      prod;

   assign t       = BITDEPTH'(phase_i >> BITFRACTION);
   assign m       = t[BITDEPTH-1];
   assign t2      = t << 1;
   assign tri_raw = m ? ~t2 : t2;

   generate
      if (BITDEPTH <= 16) begin : g_noise_trunc
         assign noise = BITDEPTH'(lfsr_i >> (16 - BITDEPTH));
      end else begin : g_noise_pad
         assign noise = {lfsr_i, {(BITDEPTH-16){1'b0}}};
      end
   endgenerate

   always_comb begin
      wave_s = '0;
      case (wave_i)
         WAVE_SAW:    wave_s = {~t[BITDEPTH-1], t[BITDEPTH-2:0]};
         WAVE_SQUARE: wave_s = m ? {1'b1, {(BITDEPTH-1){1'b0}}}
                                 : {1'b0, {(BITDEPTH-1){1'b1}}};
         WAVE_TRI:    wave_s = {~tri_raw[BITDEPTH-1], tri_raw[BITDEPTH-2:0]};
         default:     wave_s = noise;
      endcase
   end

   // Envelope is unsigned; widen both operands so the product stays exact.
   assign wave_x   = PRW'(wave_s);
   assign env_x    = PRW'(env_i);
   assign prod     = wave_x * env_x;
   assign sample_o = BITDEPTH'(prod >>> ENVBITS);

endmodule

// File: rtl/poly_synth.sv
// Time-multiplexed polyphonic synth: one voice per clock after each
// sample_clock rising edge, mixed into an offset-binary PCM word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a sample_clock rising edge
// ST_RUN  | one voice per cycle: advance phase/env, accumulate sample
// ST_OUT  | pcm/pcm_valid presented, LFSR advanced, back to idle
module poly_synth
   import poly_synth_pkg::*;
#(
   parameter int BITDEPTH     = 14,
   parameter int BITFRACTION  = 6,
   parameter int VOICES       = 4,
   parameter int ENVBITS      = 8,
   parameter int ATTACK_STEP  = 16,
   parameter int RELEASE_STEP = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                sample_clock,
   input  logic                                wr_en,
   input  logic [$clog2(VOICES)-1:0]           wr_voice,
   input  logic [BITDEPTH+BITFRACTION-1:0]     wr_increment,
   input  logic [1:0]                          wr_wave,
   input  logic                                wr_gate,
   output logic [BITDEPTH-1:0]                 pcm,
   output logic                                pcm_valid,
   output logic                                busy,
   output logic                                overrun
);

   localparam int VB  = $clog2(VOICES);
   localparam int PW  = BITDEPTH + BITFRACTION;
   localparam int AW  = BITDEPTH + VB;
   localparam int EW1 = ENVBITS + 1;
   localparam logic [EW1-1:0]      ATK_W  = EW1'(ATTACK_STEP);
   localparam logic [EW1-1:0]      EMAX_W = {1'b0, {ENVBITS{1'b1}}};
   localparam logic [ENVBITS-1:0]  REL_W  = ENVBITS'(RELEASE_STEP);
   localparam logic [BITDEPTH-1:0] MID    = {1'b1, {(BITDEPTH-1){1'b0}}};

   logic [PW-1:0]      inc_stg_q  [VOICES];
   wave_e              wave_stg_q [VOICES];
   logic               gate_stg_q [VOICES];
   logic [PW-1:0]      inc_act_q  [VOICES];
   wave_e              wave_act_q [VOICES];
   logic               gate_act_q [VOICES];
   logic [PW-1:0]      phase_q    [VOICES];
   logic [ENVBITS-1:0] env_q      [VOICES];

   state_e                state_q;
   logic                  sc_q;
   logic [VB-1:0]         vidx_q;
   logic signed [AW-1:0]  acc_q;
   logic [15:0]           lfsr_q;
   logic [BITDEPTH-1:0]   pcm_q;
   logic                  pcm_valid_q;
   logic                  busy_q;
   logic                  overrun_q;

   logic                       frame_start;
   logic [ENVBITS-1:0]         env_cur;
   logic [EW1-1:0]             env_up;
   logic [ENVBITS-1:0]         env_d;
   logic signed [BITDEPTH-1:0] sample;
   logic signed [AW-1:0]       acc_d;
   logic [BITDEPTH-1:0]        mix;
   logic [BITDEPTH-1:0]        pcm_d;

   assign frame_start = sample_clock & ~sc_q;

   poly_voice_wave #(
      .BITDEPTH    (BITDEPTH),
      .BITFRACTION (BITFRACTION),
      .ENVBITS     (ENVBITS)
   ) u_wave (
      .phase_i  (phase_q[vidx_q]),
      .wave_i   (wave_act_q[vidx_q]),
      .env_i    (env_q[vidx_q]),
      .lfsr_i   (lfsr_q),
      .sample_o (sample)
   );

   assign env_cur = env_q[vidx_q];
   assign env_up  = {1'b0, env_cur} + ATK_W;
   assign env_d   = gate_act_q[vidx_q]
                    ? ((env_up > EMAX_W) ? {ENVBITS{1'b1}} : env_up[ENVBITS-1:0])
                    : ((env_cur < REL_W) ? '0 : env_cur - REL_W);

   // Sum of VOICES samples cannot exceed AW bits, so no saturation is needed.
   assign acc_d = acc_q + AW'(sample);
   assign mix   = BITDEPTH'(acc_d >>> VB);
   assign pcm_d = mix ^ MID;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sc_q        <= 1'b0;
         vidx_q      <= '0;
         acc_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         pcm_q       <= MID;
         pcm_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            inc_stg_q[v]  <= '0;
            wave_stg_q[v] <= WAVE_SAW;
            gate_stg_q[v] <= 1'b0;
            inc_act_q[v]  <= '0;
            wave_act_q[v] <= WAVE_SAW;
            gate_act_q[v] <= 1'b0;
            phase_q[v]    <= '0;
            env_q[v]      <= '0;
         end
      end else begin
         sc_q        <= sample_clock;
         pcm_valid_q <= 1'b0;
         if (wr_en) begin
            inc_stg_q[wr_voice]  <= wr_increment;
            wave_stg_q[wr_voice] <= wave_e'(wr_wave);
            gate_stg_q[wr_voice] <= wr_gate;
         end
         if (frame_start && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (frame_start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  vidx_q  <= '0;
                  acc_q   <= '0;
                  for (int v = 0; v < VOICES; v++) begin
                     inc_act_q[v]  <= inc_stg_q[v];
                     wave_act_q[v] <= wave_stg_q[v];
                     gate_act_q[v] <= gate_stg_q[v];
                  end
               end
            end
            ST_RUN: begin
               phase_q[vidx_q] <= phase_q[vidx_q] + inc_act_q[vidx_q];
               env_q[vidx_q]   <= env_d;
               acc_q           <= acc_d;
               vidx_q          <= vidx_q + VB'(1);
               if (vidx_q == VB'(VOICES-1)) begin
                  state_q     <= ST_OUT;
                  pcm_q       <= pcm_d;
                  pcm_valid_q <= 1'b1;
               end
            end
            ST_OUT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               lfsr_q  <= lfsr_next(lfsr_q);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pcm       = pcm_q;
   assign pcm_valid = pcm_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_poly_synth.sv
// Directed bench for poly_synth with hand-computed PCM values for
// saw/square voices, frame timing, overrun and mid-frame reset.
module tb_poly_synth;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_clock = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_voice = '0;
   logic [19:0] wr_increment = '0;
   logic [1:0]  wr_wave = '0;
   logic        wr_gate = 1'b0;
   logic [13:0] pcm;
   logic        pcm_valid;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [1:0]  mw_voice;
   logic [19:0] mw_inc;
   logic [1:0]  mw_wave;
   logic        mw_gate;

   poly_synth dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_clock (sample_clock),
      .wr_en        (wr_en),
      .wr_voice     (wr_voice),
      .wr_increment (wr_increment),
      .wr_wave      (wr_wave),
      .wr_gate      (wr_gate),
      .pcm          (pcm),
      .pcm_valid    (pcm_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic write_voice(input logic [1:0] v, input logic [19:0] inc,
                              input logic [1:0] w, input logic g);
      @(negedge clk);
      wr_en = 1'b1; wr_voice = v; wr_increment = inc; wr_wave = w; wr_gate = g;
      @(negedge clk) wr_en = 1'b0;
   endtask

   // exp_pcm < 0 skips the value check but keeps the timing checks.
   task automatic run_frame(input int exp_pcm, input string tag, input bit mid_wr);
      int n;
      bit seen;
      @(negedge clk) sample_clock = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy"}, busy, 1);
      @(negedge clk) sample_clock = 1'b0;
      if (mid_wr) begin
         wr_en = 1'b1; wr_voice = mw_voice; wr_increment = mw_inc;
         wr_wave = mw_wave; wr_gate = mw_gate;
      end
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         n++;
         if (pcm_valid) seen = 1;
      end
      chk({tag, "_lat"}, n, 4);
      if (exp_pcm >= 0) chk({tag, "_pcm"}, pcm, exp_pcm);
      @(posedge clk); #1;
      chk({tag, "_vld_drop"}, pcm_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int vcount;
      int n;

      // reset state
      repeat (2) @(posedge clk); #1;
      chk("rst_pcm", pcm, 8192);
      chk("rst_valid", pcm_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      @(negedge clk) rst_n = 1'b1;

      // silence: no writes
      for (int i = 0; i < 10; i++) run_frame(8192, "silence", 0);
      chk("silence_overrun", overrun, 0);

      // voice 0 saw, increment 2^14, attack to saturation
      do_reset();
      write_voice(2'd0, 20'd16384, 2'd0, 1'b1);
      run_frame(8192, "saw_f1", 0);
      run_frame(8068, "saw_f2", 0);
      run_frame(7952, "saw_f3", 0);
      run_frame(7844, "saw_f4", 0);
      for (int i = 5; i <= 15; i++) run_frame(-1, "saw_mid", 0);
      run_frame(7172, "saw_f16", 0);
      run_frame(7172, "saw_f17", 0);
      run_frame(7235, "saw_f18_sat", 0);

      // voice 1 square: attack to EMAX, then release to silence
      do_reset();
      write_voice(2'd1, 20'd0, 2'd1, 1'b1);
      run_frame(8192, "sq_f1", 0);
      run_frame(8319, "sq_f2", 0);
      for (int i = 3; i <= 16; i++) run_frame(-1, "sq_att", 0);
      run_frame(10231, "sq_f17_max", 0);
      write_voice(2'd1, 20'd0, 2'd1, 1'b0);
      run_frame(10231, "sq_rel1", 0);
      run_frame(10199, "sq_rel2", 0);
      for (int i = 3; i <= 63; i++) run_frame(-1, "sq_rel", 0);
      run_frame(8215, "sq_rel64", 0);
      run_frame(8192, "sq_rel65_zero", 0);

      // write during RUN only affects the following frame
      do_reset();
      write_voice(2'd2, 20'd16384, 2'd0, 1'b1);
      run_frame(8192, "mw_f1", 0);
      run_frame(8068, "mw_f2", 0);
      mw_voice = 2'd2; mw_inc = 20'd65536; mw_wave = 2'd0; mw_gate = 1'b1;
      run_frame(7952, "mw_f3", 1);
      run_frame(7844, "mw_f4", 0);
      run_frame(7792, "mw_f5", 0);

      // second rising edge at E+2 while busy
      @(negedge clk) sample_clock = 1'b1;
      @(posedge clk);
      @(negedge clk) sample_clock = 1'b0;
      @(posedge clk);
      @(negedge clk) sample_clock = 1'b1;
      @(posedge clk); #1;
      chk("ovr_set", overrun, 1);
      @(negedge clk) sample_clock = 1'b0;
      n = 0;
      while (!pcm_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ovr_frame_lat", n, 2);
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (pcm_valid) vcount++;
      end
      chk("ovr_no_restart", vcount, 0);
      run_frame(-1, "ovr_next", 0);
      chk("ovr_sticky", overrun, 1);

      // reset asserted at E+2 aborts the frame
      @(negedge clk) sample_clock = 1'b1;
      @(posedge clk);
      @(negedge clk) sample_clock = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("abort_busy_now", busy, 0);
      @(posedge clk); #1;
      chk("abort_pcm", pcm, 8192);
      chk("abort_busy", busy, 0);
      chk("abort_valid", pcm_valid, 0);
      chk("abort_overrun", overrun, 0);
      vcount = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (pcm_valid) vcount++;
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (pcm_valid) vcount++;
      end
      chk("abort_no_valid", vcount, 0);
      run_frame(8192, "after_abort", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
